// File: rtl/decode_stage.sv
// ---------------------------------------------------------------------------
// decode_stage
//
// RV32I decode pipeline stage that sits between fetch and execute.
//
// Each cycle it can accept one instruction from fetch. When it accepts one, it
// captures the PC, the raw word, the register indices, the sign-extended
// immediate and the illegal-opcode flag into a holding register. It also
// issues the rs1/rs2 read addresses to the register file. The register file
// returns the data one cycle later, and that data feeds the execute operands
// directly.
//
// Optional feature macro: DECODE_WB_BYPASS_EN
//   Defined   : A writeback that targets an address being read in the same
//               cycle is captured and substituted for the register file's
//               read-old data in the following cycle.
//   Undefined : Operands come straight from the register file response. There
//               is no bypass logic, so a same-cycle write returns stale data.
//
// Ports
//   i_clk          core clock
//   i_rst          synchronous reset, active-low
//   i_flush        discard the held instruction (redirect)
//   i_if_valid     fetch offers an instruction
//   o_if_ready     decode accepts this cycle
//   i_if_instr     instruction word from fetch
//   i_if_pc        instruction address from fetch
//   o_rf_r_req     register file read addresses (rs1, rs2)
//   i_rf_r_resp    registered register file read data
//   i_wb_w_req     writeback port, snooped for bypass
//   o_ex_valid     decoded instruction available to execute
//   i_ex_ready     execute accepts
//   o_ex_pc        held PC
//   o_ex_instr     held raw instruction word
//   o_ex_rs1_data  rs1 operand
//   o_ex_rs2_data  rs2 operand
//   o_ex_rd        destination register index
//   o_ex_rs1       rs1 index
//   o_ex_rs2       rs2 index
//   o_ex_imm       sign-extended immediate
//   o_ex_illegal   unsupported opcode
//
// Handshake semantics (both sides)
//   A transfer happens on a rising edge where valid && ready are both high.
//   While a producer is holding valid high, it keeps its payload stable until
//   the transfer happens. The ready signal may depend on the consumer's own
//   state and on flush/reset, but never on the valid signal it is paired with.
//   Flush overrides both transfers in the cycle where it is asserted.
// ---------------------------------------------------------------------------

package decode_pkg;

  typedef struct packed {
    logic [4:0] r_addr_1;
    logic [4:0] r_addr_2;
  } regfile_r_req_st;

  typedef struct packed {
    logic [31:0] r_data_1;
    logic [31:0] r_data_2;
  } regfile_r_resp_st;

  typedef struct packed {
    logic        w_en;
    logic [4:0]  w_addr;
    logic [31:0] w_data;
  } regfile_w_req_st;

endpackage

module decode_stage
  import decode_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_flush,
  input  logic             i_if_valid,
  output logic             o_if_ready,
  input  logic [31:0]      i_if_instr,
  input  logic [31:0]      i_if_pc,
  output regfile_r_req_st  o_rf_r_req,
  input  regfile_r_resp_st i_rf_r_resp,
  input  regfile_w_req_st  i_wb_w_req,
  output logic             o_ex_valid,
  input  logic             i_ex_ready,
  output logic [31:0]      o_ex_pc,
  output logic [31:0]      o_ex_instr,
  output logic [31:0]      o_ex_rs1_data,
  output logic [31:0]      o_ex_rs2_data,
  output logic [4:0]       o_ex_rd,
  output logic [4:0]       o_ex_rs1,
  output logic [4:0]       o_ex_rs2,
  output logic [31:0]      o_ex_imm,
  output logic             o_ex_illegal
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // Holding register
  logic        valid_q,   valid_d;
  logic [31:0] pc_q,      pc_d;
  logic [31:0] instr_q,   instr_d;
  logic [4:0]  rd_q,      rd_d;
  logic [4:0]  rs1_q,     rs1_d;
  logic [4:0]  rs2_q,     rs2_d;
  logic [31:0] imm_q,     imm_d;
  logic        illegal_q, illegal_d;

  logic        accept;
  logic [31:0] dec_imm;
  logic        dec_illegal;

  assign o_if_ready = i_rst && !i_flush && (!valid_q || i_ex_ready);
  assign accept     = i_if_valid && o_if_ready;

  // When accepting, read the sources of the incoming word. Otherwise re-read
  // the held sources, so the response always belongs to the held instruction.
  assign o_rf_r_req.r_addr_1 = accept ? i_if_instr[19:15] : rs1_q;
  assign o_rf_r_req.r_addr_2 = accept ? i_if_instr[24:20] : rs2_q;

  // Immediate decode of the incoming word
  always_comb begin
    dec_imm     = '0;
    dec_illegal = 1'b0;
    case (i_if_instr[6:0])
      OP_IMM, OP_LOAD, OP_JALR:
        dec_imm = {{20{i_if_instr[31]}}, i_if_instr[31:20]};
      OP_STORE:
        dec_imm = {{20{i_if_instr[31]}}, i_if_instr[31:25], i_if_instr[11:7]};
      OP_BRANCH:
        dec_imm = {{19{i_if_instr[31]}}, i_if_instr[31], i_if_instr[7],
                   i_if_instr[30:25], i_if_instr[11:8], 1'b0};
      OP_LUI, OP_AUIPC:
        dec_imm = {i_if_instr[31:12], 12'b0};
      OP_JAL:
        dec_imm = {{11{i_if_instr[31]}}, i_if_instr[31], i_if_instr[19:12],
                   i_if_instr[20], i_if_instr[30:21], 1'b0};
      OP_REG, OP_SYSTEM, OP_FENCE:
        dec_imm = '0;
      default:
        dec_illegal = 1'b1;
    endcase
  end

  always_comb begin
    pc_d      = pc_q;
    instr_d   = instr_q;
    rd_d      = rd_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    imm_d     = imm_q;
    illegal_d = illegal_q;
    valid_d   = valid_q;

    if (accept) begin
      pc_d      = i_if_pc;
      instr_d   = i_if_instr;
      rd_d      = i_if_instr[11:7];
      rs1_d     = i_if_instr[19:15];
      rs2_d     = i_if_instr[24:20];
      imm_d     = dec_imm;
      illegal_d = dec_illegal;
    end

    // Flush wins. Accept refills the slot. A handshake without a refill empties it.
    if (i_flush)         valid_d = 1'b0;
    else if (accept)     valid_d = 1'b1;
    else if (i_ex_ready) valid_d = 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      valid_q   <= 1'b0;
      pc_q      <= '0;
      instr_q   <= '0;
      rd_q      <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      imm_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      rd_q      <= rd_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      imm_q     <= imm_d;
      illegal_q <= illegal_d;
    end
  end

`ifdef DECODE_WB_BYPASS_EN
  // The register file returns pre-write data when a write and a read of the
  // same address share a cycle. Capture such a write so it can be substituted
  // next cycle. This runs every cycle, so stall re-reads also pick up writes.
  logic        hit1_q, hit1_d;
  logic        hit2_q, hit2_d;
  logic [31:0] byp1_q, byp1_d;
  logic [31:0] byp2_q, byp2_d;

  always_comb begin
    hit1_d = i_wb_w_req.w_en && (i_wb_w_req.w_addr != 5'd0) &&
             (i_wb_w_req.w_addr == o_rf_r_req.r_addr_1);
    hit2_d = i_wb_w_req.w_en && (i_wb_w_req.w_addr != 5'd0) &&
             (i_wb_w_req.w_addr == o_rf_r_req.r_addr_2);
    byp1_d = i_wb_w_req.w_data;
    byp2_d = i_wb_w_req.w_data;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      hit1_q <= 1'b0;
      hit2_q <= 1'b0;
      byp1_q <= '0;
      byp2_q <= '0;
    end else begin
      hit1_q <= hit1_d;
      hit2_q <= hit2_d;
      byp1_q <= byp1_d;
      byp2_q <= byp2_d;
    end
  end

  assign o_ex_rs1_data = hit1_q ? byp1_q : i_rf_r_resp.r_data_1;
  assign o_ex_rs2_data = hit2_q ? byp2_q : i_rf_r_resp.r_data_2;
`else
  logic unused_wb;
  assign unused_wb     = ^i_wb_w_req;
  assign o_ex_rs1_data = i_rf_r_resp.r_data_1;
  assign o_ex_rs2_data = i_rf_r_resp.r_data_2;
`endif

  assign o_ex_valid   = valid_q;
  assign o_ex_pc      = pc_q;
  assign o_ex_instr   = instr_q;
  assign o_ex_rd      = rd_q;
  assign o_ex_rs1     = rs1_q;
  assign o_ex_rs2     = rs2_q;
  assign o_ex_imm     = imm_q;
  assign o_ex_illegal = illegal_q;

endmodule

// File: tb/tb_decode_stage.sv
// ---------------------------------------------------------------------------
// tb_decode_stage
//
// Directed bench for decode_stage. A small register file model sits around
// the DUT. The model returns registered read data, and a write in the same
// cycle as a read is not visible to that read. Expected decode results are
// queued when an instruction is offered to the DUT. They are popped and
// compared when the instruction reaches the execute side.
// ---------------------------------------------------------------------------

module tb_decode_stage;
  import decode_pkg::*;

`ifdef DECODE_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] imm;
    logic [31:0] rs1d;
    logic [31:0] rs2d;
    logic [4:0]  rd;
    logic        ill;
  } exp_t;

  // ---------------- clock / reset / DUT ----------------
  logic             i_clk = 1'b0;
  logic             i_rst;
  logic             i_flush;
  logic             i_if_valid;
  logic             o_if_ready;
  logic [31:0]      i_if_instr;
  logic [31:0]      i_if_pc;
  regfile_r_req_st  rf_req;
  regfile_r_resp_st rf_resp;
  regfile_w_req_st  wb;
  logic             o_ex_valid;
  logic             i_ex_ready;
  logic [31:0]      o_ex_pc, o_ex_instr, o_ex_rs1_data, o_ex_rs2_data, o_ex_imm;
  logic [4:0]       o_ex_rd, o_ex_rs1, o_ex_rs2;
  logic             o_ex_illegal;

  always #5 i_clk = ~i_clk;

  decode_stage dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_flush       (i_flush),
    .i_if_valid    (i_if_valid),
    .o_if_ready    (o_if_ready),
    .i_if_instr    (i_if_instr),
    .i_if_pc       (i_if_pc),
    .o_rf_r_req    (rf_req),
    .i_rf_r_resp   (rf_resp),
    .i_wb_w_req    (wb),
    .o_ex_valid    (o_ex_valid),
    .i_ex_ready    (i_ex_ready),
    .o_ex_pc       (o_ex_pc),
    .o_ex_instr    (o_ex_instr),
    .o_ex_rs1_data (o_ex_rs1_data),
    .o_ex_rs2_data (o_ex_rs2_data),
    .o_ex_rd       (o_ex_rd),
    .o_ex_rs1      (o_ex_rs1),
    .o_ex_rs2      (o_ex_rs2),
    .o_ex_imm      (o_ex_imm),
    .o_ex_illegal  (o_ex_illegal)
  );

  // Register file model: registered read, read-old-data on collision, x0 = 0
  logic [31:0] rf_mem [32];

  always @(posedge i_clk) begin
    rf_resp.r_data_1 <= rf_mem[rf_req.r_addr_1];
    rf_resp.r_data_2 <= rf_mem[rf_req.r_addr_2];
    if (!i_rst) begin
      for (int i = 0; i < 32; i++) rf_mem[i] <= '0;
    end else if (wb.w_en && wb.w_addr != 5'd0) begin
      rf_mem[wb.w_addr] <= wb.w_data;
    end
  end

  // ---------------- scoreboard ----------------
  exp_t exp_q[$];
  int   pass_cnt  = 0;
  int   fail_cnt  = 0;
  int   total_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic send(input logic [31:0] pc, input logic [31:0] instr,
                      input logic [31:0] imm, input logic [31:0] rs1d,
                      input logic [31:0] rs2d, input logic [4:0] rd,
                      input logic ill);
    exp_t e;
    i_if_valid = 1'b1;
    i_if_instr = instr;
    i_if_pc    = pc;
    e.pc = pc; e.instr = instr; e.imm = imm; e.rs1d = rs1d; e.rs2d = rs2d;
    e.rd = rd; e.ill = ill;
    exp_q.push_back(e);
  endtask

  task automatic wb_write(input logic [4:0] addr, input logic [31:0] data);
    wb.w_en   = 1'b1;
    wb.w_addr = addr;
    wb.w_data = data;
  endtask

  task automatic expect_pop(input string tag);
    exp_t e;
    chk({tag, ".valid"}, 32'(o_ex_valid), 32'd1);
    chk({tag, ".queued"}, 32'(exp_q.size() != 0), 32'd1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk({tag, ".pc"},      o_ex_pc,            e.pc);
      chk({tag, ".instr"},   o_ex_instr,         e.instr);
      chk({tag, ".imm"},     o_ex_imm,           e.imm);
      chk({tag, ".rs1_data"}, o_ex_rs1_data,     e.rs1d);
      chk({tag, ".rs2_data"}, o_ex_rs2_data,     e.rs2d);
      chk({tag, ".rd"},      32'(o_ex_rd),       32'(e.rd));
      chk({tag, ".illegal"}, 32'(o_ex_illegal),  32'(e.ill));
    end
  endtask

  // Table of back-to-back instructions (x1=0x1234, x2=0xAA at that point)
  logic [31:0] t_instr [5] = '{32'hFE20AC23, 32'h00208863, 32'hABCDE2B7,
                               32'hFE000FE3, 32'h7FF12303};
  logic [31:0] t_imm   [5] = '{32'hFFFFFFF8, 32'h00000010, 32'hABCDE000,
                               32'hFFFFFFFE, 32'h000007FF};
  logic [31:0] t_rs1d  [5] = '{32'h1234, 32'h1234, 32'h0, 32'h0, 32'hAA};
  logic [31:0] t_rs2d  [5] = '{32'hAA, 32'hAA, 32'h0, 32'h0, 32'h0};
  logic [4:0]  t_rd    [5] = '{5'd24, 5'd16, 5'd5, 5'd31, 5'd6};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic [31:0] rpc;
    i_rst      = 1'b0;
    i_flush    = 1'b0;
    i_if_valid = 1'b1;
    i_if_instr = 32'hFFF08193;
    i_if_pc    = 32'h40;
    i_ex_ready = 1'b1;
    wb         = '0;

    // Reset held for 3 cycles while fetch offers an instruction
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("rst.valid",   32'(o_ex_valid),   32'd0);
      chk("rst.ready",   32'(o_if_ready),   32'd0);
      chk("rst.pc",      o_ex_pc,           32'd0);
      chk("rst.instr",   o_ex_instr,        32'd0);
      chk("rst.imm",     o_ex_imm,          32'd0);
      chk("rst.illegal", 32'(o_ex_illegal), 32'd0);
      chk("rst.idx",     32'({o_ex_rd, o_ex_rs1, o_ex_rs2}), 32'd0);
    end
    i_rst      = 1'b1;
    i_if_valid = 1'b0;
    #1;
    chk("rel.ready", 32'(o_if_ready), 32'd1);

    // Preload x1=5, x2=7
    wb_write(5'd1, 32'd5);
    tick();
    wb_write(5'd2, 32'd7);
    tick();
    wb.w_en = 1'b0;

    // Back-to-back: addi x3,x1,-1 then add x4,x1,x2
    send(32'h100, 32'hFFF08193, 32'hFFFFFFFF, 32'd5, 32'd0, 5'd3, 1'b0);
    tick();
    expect_pop("b2b_addi");
    send(32'h104, 32'h00208233, 32'd0, 32'd5, 32'd7, 5'd4, 1'b0);
    tick();
    expect_pop("b2b_add");

    // Collision: accept add while x1 is written with 0x1234
    send(32'h108, 32'h00208233, 32'd0, BYP ? 32'h1234 : 32'd5, 32'd7, 5'd4, 1'b0);
    wb_write(5'd1, 32'h1234);
    tick();
    expect_pop("collide");
    wb.w_en = 1'b0;

    // Stall: hold ready low 4 cycles, write x2=0xAA in stall cycle 2
    send(32'h10C, 32'h00208233, 32'd0, 32'h1234, 32'hAA, 5'd4, 1'b0);
    tick();
    i_ex_ready = 1'b0;
    i_if_instr = 32'h002002B3;          // add x5,x0,x2 offered, must wait
    i_if_pc    = 32'h110;
    #1;
    chk("stall1.ready",    32'(o_if_ready), 32'd0);
    chk("stall1.valid",    32'(o_ex_valid), 32'd1);
    chk("stall1.pc",       o_ex_pc,         32'h10C);
    chk("stall1.rs2_data", o_ex_rs2_data,   32'd7);
    tick();
    chk("stall2.ready",    32'(o_if_ready), 32'd0);
    chk("stall2.instr",    o_ex_instr,      32'h00208233);
    chk("stall2.rs2_data", o_ex_rs2_data,   32'd7);
    wb_write(5'd2, 32'hAA);
    tick();
    wb.w_en = 1'b0;
    chk("stall3.ready",    32'(o_if_ready), 32'd0);
    chk("stall3.pc",       o_ex_pc,         32'h10C);
    chk("stall3.rs1_data", o_ex_rs1_data,   32'h1234);
    chk("stall3.rs2_data", o_ex_rs2_data,   BYP ? 32'hAA : 32'd7);
    tick();
    chk("stall4.ready",    32'(o_if_ready), 32'd0);
    expect_pop("stall");

    // Release; accept add x5,x0,x2 while x0 is written with 0xFFFF
    i_ex_ready = 1'b1;
    send(32'h110, 32'h002002B3, 32'd0, 32'd0, 32'hAA, 5'd5, 1'b0);
    wb_write(5'd0, 32'hFFFF);
    #1;
    chk("release.ready", 32'(o_if_ready), 32'd1);
    tick();
    wb.w_en = 1'b0;
    expect_pop("x0_write");

    // Flush while stalled with valid=1; offered word must not be taken
    i_flush    = 1'b1;
    i_ex_ready = 1'b0;
    i_if_valid = 1'b1;
    i_if_instr = 32'h00208233;
    i_if_pc    = 32'h114;
    #1;
    chk("flush.ready", 32'(o_if_ready), 32'd0);
    tick();
    chk("flush.valid", 32'(o_ex_valid), 32'd0);
    i_flush    = 1'b0;
    i_ex_ready = 1'b1;

    // jal x1,-4 then illegal opcode 0x7F
    send(32'h200, 32'hFFDFF0EF, 32'hFFFFFFFC, 32'd0, 32'd0, 5'd1, 1'b0);
    tick();
    expect_pop("jal");
    send(32'h204, 32'hFFF0807F, 32'd0, 32'h1234, 32'd0, 5'd0, 1'b1);
    tick();
    expect_pop("illegal");

    // Immediate formats, one per cycle
    for (int k = 0; k < 5; k++) begin
      rpc = 32'($urandom_range(0, 32'h3FFF)) << 2;
      send(rpc, t_instr[k], t_imm[k], t_rs1d[k], t_rs2d[k], t_rd[k], 1'b0);
      tick();
      expect_pop($sformatf("imm%0d", k));
    end
    i_if_valid = 1'b0;
    tick();
    chk("drain.valid", 32'(o_ex_valid), 32'd0);

    // Reset mid-stall drops the held instruction
    i_if_valid = 1'b1;
    i_if_instr = 32'h00208233;
    i_if_pc    = 32'h300;
    tick();
    i_if_valid = 1'b0;
    i_ex_ready = 1'b0;
    chk("rstmid.valid_before", 32'(o_ex_valid), 32'd1);
    i_rst = 1'b0;
    tick();
    chk("rstmid.valid", 32'(o_ex_valid), 32'd0);
    chk("rstmid.pc",    o_ex_pc,         32'd0);
    chk("rstmid.instr", o_ex_instr,      32'd0);
    chk("rstmid.ready", 32'(o_if_ready), 32'd0);
    i_rst = 1'b1;
    tick();
    chk("after_rst.valid", 32'(o_ex_valid), 32'd0);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
